// File: rtl/cable_launch_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cable_launch_controller_if                                      |
// | Purpose  : Game-side inputs and cable command outputs of the controller.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface cable_launch_controller_if;
  logic       startOfFrame;
  logic       gameEnable;
  logic       launchKey;
  logic       hookAtHome;
  logic       hitGold;
  logic       hitRock;
  logic       hitEdge;
  logic       launch_Cable;
  logic       reverseCable;
  logic [1:0] reelSpeedSel;
  logic [1:0] carriedObj;
  logic       scoreValid;
  logic [7:0] scoreAdd;
  logic       busy;

  modport master (
    output startOfFrame, gameEnable, launchKey, hookAtHome, hitGold, hitRock, hitEdge,
    input  launch_Cable, reverseCable, reelSpeedSel, carriedObj, scoreValid, scoreAdd, busy
  );

  modport slave (
    input  startOfFrame, gameEnable, launchKey, hookAtHome, hitGold, hitRock, hitEdge,
    output launch_Cable, reverseCable, reelSpeedSel, carriedObj, scoreValid, scoreAdd, busy
  );
endinterface
`default_nettype wire

// File: rtl/cable_launch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cable_launch_controller                                         |
// | Purpose  : Launch/reverse/score sequencing for the swinging hook cable.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cable_launch_controller #(
  parameter int unsigned EXTEND_TIMEOUT_FRAMES = 90,
  parameter int unsigned COOLDOWN_FRAMES       = 15,
  parameter logic [7:0]  GOLD_VALUE            = 8'd50,
  parameter logic [7:0]  ROCK_VALUE            = 8'd10
) (
  input  logic                     clk,
  input  logic                     resetN,
  cable_launch_controller_if.slave bus
);
  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_LAUNCH   = 3'd1;
  localparam logic [2:0] c_EXTEND   = 3'd2;
  localparam logic [2:0] c_REVERSE  = 3'd3;
  localparam logic [2:0] c_RETRACT  = 3'd4;
  localparam logic [2:0] c_SCORE    = 3'd5;
  localparam logic [2:0] c_COOLDOWN = 3'd6;

  localparam logic [1:0] c_OBJ_NONE = 2'd0;
  localparam logic [1:0] c_OBJ_GOLD = 2'd1;
  localparam logic [1:0] c_OBJ_ROCK = 2'd2;

  localparam logic [7:0] c_EXT_LIMIT = 8'(EXTEND_TIMEOUT_FRAMES);
  localparam logic [7:0] c_CD_LIMIT  = 8'(COOLDOWN_FRAMES);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [1:0] r_carried;
  logic [1:0] w_carried_nxt;
  logic [7:0] r_frame_cnt;
  logic [7:0] w_frame_cnt_inc;
  logic       r_key_d;
  logic       w_key_rise;
  logic       r_ret_seen;
  logic       r_launch;
  logic       r_reverse;
  logic       r_score_valid;
  logic [7:0] r_score_add;
  logic [1:0] r_reel_sel;
  logic       r_busy;

  assign w_key_rise      = bus.launchKey & ~r_key_d;
  // Saturating so a stalled frame count can never wrap back under a limit
  assign w_frame_cnt_inc = (bus.startOfFrame && (r_frame_cnt != 8'hFF)) ?
                           (r_frame_cnt + 8'd1) : r_frame_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_carried_nxt = r_carried;
    case (r_state)
      c_IDLE:
        if (w_key_rise && bus.gameEnable && bus.hookAtHome) w_state_nxt = c_LAUNCH;
      c_LAUNCH:
        w_state_nxt = c_EXTEND;
      c_EXTEND: begin
        if (bus.hitGold) begin
          w_carried_nxt = c_OBJ_GOLD;
          w_state_nxt   = c_REVERSE;
        end else if (bus.hitRock) begin
          w_carried_nxt = c_OBJ_ROCK;
          w_state_nxt   = c_REVERSE;
        end else if (bus.hitEdge || (w_frame_cnt_inc >= c_EXT_LIMIT)) begin
          w_carried_nxt = c_OBJ_NONE;
          w_state_nxt   = c_REVERSE;
        end
      end
      c_REVERSE:
        w_state_nxt = c_RETRACT;
      c_RETRACT:
        if (bus.hookAtHome && r_ret_seen) w_state_nxt = c_SCORE;
      c_SCORE: begin
        w_carried_nxt = c_OBJ_NONE;
        w_state_nxt   = c_COOLDOWN;
      end
      c_COOLDOWN:
        if (w_frame_cnt_inc >= c_CD_LIMIT) w_state_nxt = c_IDLE;
      default: begin
        w_carried_nxt = c_OBJ_NONE;
        w_state_nxt   = c_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pulse lines up with its state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= c_IDLE;
      r_carried     <= c_OBJ_NONE;
      r_frame_cnt   <= 8'd0;
      r_key_d       <= 1'b0;
      r_ret_seen    <= 1'b0;
      r_launch      <= 1'b0;
      r_reverse     <= 1'b0;
      r_score_valid <= 1'b0;
      r_score_add   <= 8'd0;
      r_reel_sel    <= 2'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_carried  <= w_carried_nxt;
      r_key_d    <= bus.launchKey;
      r_launch   <= (w_state_nxt == c_LAUNCH);
      r_reverse  <= (w_state_nxt == c_REVERSE);
      r_busy     <= (w_state_nxt != c_IDLE);
      r_reel_sel <= (w_state_nxt == c_RETRACT) ? w_carried_nxt : 2'd0;

      if ((w_state_nxt == c_SCORE) && (r_carried != c_OBJ_NONE)) begin
        r_score_valid <= 1'b1;
        r_score_add   <= (r_carried == c_OBJ_GOLD) ? GOLD_VALUE : ROCK_VALUE;
      end else begin
        r_score_valid <= 1'b0;
        r_score_add   <= 8'd0;
      end

      if ((r_state == c_EXTEND) || (r_state == c_COOLDOWN)) r_frame_cnt <= w_frame_cnt_inc;
      else                                                  r_frame_cnt <= 8'd0;

      // A frame boundary must pass in RETRACT before a home hook counts as returned
      r_ret_seen <= (r_state == c_RETRACT) ? (r_ret_seen | bus.startOfFrame) : 1'b0;
    end
  end

  assign bus.launch_Cable = r_launch;
  assign bus.reverseCable = r_reverse;
  assign bus.reelSpeedSel = r_reel_sel;
  assign bus.carriedObj   = r_carried;
  assign bus.scoreValid   = r_score_valid;
  assign bus.scoreAdd     = r_score_add;
  assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_cable_launch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cable_launch_controller                                      |
// | Purpose  : Scoreboard bench for the cable launch controller.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cable_launch_controller;
  localparam int TO = 4;
  localparam int CD = 15;
  localparam int FP = 8;
  localparam int EV_LAUNCH = 1;
  localparam int EV_REV    = 2;
  localparam int EV_SCORE  = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  ev_t  exp_q[$];

  cable_launch_controller_if bus();

  cable_launch_controller #(
    .EXTEND_TIMEOUT_FRAMES(TO),
    .COOLDOWN_FRAMES      (CD),
    .GOLD_VALUE           (8'd50),
    .ROCK_VALUE           (8'd10)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(kind), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_val", 32'(val), 32'(e.val));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 launch, 1 reverse, 2 scoreValid, 3 back to idle
  task automatic wait_out(input int which, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.launch_Cable) || (which == 1 && bus.reverseCable) ||
          (which == 2 && bus.scoreValid)   || (which == 3 && !bus.busy)) return;
    end
    check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_sof(input int n);
    int k;
    k = 0;
    for (int i = 0; i < n * FP * 2 && k < n; i++) begin
      @(posedge clk);
      if (bus.startOfFrame) k++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_launch"}, 32'(bus.launch_Cable), 32'd0);
    check({tag, "_reverse"}, 32'(bus.reverseCable), 32'd0);
    check({tag, "_valid"}, 32'(bus.scoreValid), 32'd0);
    check({tag, "_add"}, 32'(bus.scoreAdd), 32'd0);
    check({tag, "_carried"}, 32'(bus.carriedObj), 32'd0);
    check({tag, "_reel"}, 32'(bus.reelSpeedSel), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      check("reel_never_3", 32'(bus.reelSpeedSel != 2'd3), 32'd1);
      if (!bus.scoreValid) check("add_zero_when_idle", 32'(bus.scoreAdd), 32'd0);
      if (bus.launch_Cable) sb_pop(EV_LAUNCH, 0);
      if (bus.reverseCable) sb_pop(EV_REV, int'(bus.carriedObj));
      if (bus.scoreValid)   sb_pop(EV_SCORE, int'(bus.scoreAdd));
    end
  end

  initial begin
    bus.startOfFrame = 1'b0;
    forever begin
      repeat (FP - 1) @(posedge clk);
      #1 bus.startOfFrame = 1'b1;
      @(posedge clk);
      #1 bus.startOfFrame = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.gameEnable = 1'b1;
    bus.launchKey  = 1'b0;
    bus.hookAtHome = 1'b1;
    bus.hitGold    = 1'b0;
    bus.hitRock    = 1'b0;
    bus.hitEdge    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step();
    resetN = 1'b1;
    repeat (8) step();

    // Basic launch with key held, then gold+rock simultaneous hit
    bus.launchKey = 1'b1;
    sb_push(EV_LAUNCH, 0);
    @(negedge clk);
    check("pre_launch", 32'(bus.launch_Cable), 32'd0);
    check("pre_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("launch_next_cycle", 32'(bus.launch_Cable), 32'd1);
    check("busy_with_launch", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("launch_one_cycle", 32'(bus.launch_Cable), 32'd0);
    check("busy_in_extend", 32'(bus.busy), 32'd1);
    step();
    bus.hookAtHome = 1'b0;
    bus.hitGold    = 1'b1;
    bus.hitRock    = 1'b1;
    sb_push(EV_REV, 1);
    sb_push(EV_SCORE, 50);
    @(posedge clk);
    #1;
    bus.hitGold = 1'b0;
    bus.hitRock = 1'b0;
    @(negedge clk);
    check("gold_reverse", 32'(bus.reverseCable), 32'd1);
    check("gold_carried", 32'(bus.carriedObj), 32'd1);
    @(negedge clk);
    check("gold_reverse_one_cycle", 32'(bus.reverseCable), 32'd0);
    check("gold_reel_medium", 32'(bus.reelSpeedSel), 32'd1);
    wait_sof(3);
    #1 bus.hookAtHome = 1'b1;
    wait_out(2, 200, "gold_score_timeout");
    check("gold_score_add", 32'(bus.scoreAdd), 32'd50);
    @(negedge clk);
    check("gold_valid_one_cycle", 32'(bus.scoreValid), 32'd0);
    check("gold_carried_cleared", 32'(bus.carriedObj), 32'd0);
    check("gold_reel_cleared", 32'(bus.reelSpeedSel), 32'd0);
    wait_out(3, 400, "gold_idle_timeout");
    repeat (700) step();
    bus.launchKey = 1'b0;

    // Timeout miss
    step();
    bus.launchKey = 1'b1;
    sb_push(EV_LAUNCH, 0);
    sb_push(EV_REV, 0);
    wait_out(0, 10, "to_launch_timeout");
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 200 && n < TO; i++) begin
      @(posedge clk);
      if (bus.startOfFrame) begin
        n++;
        if (n < TO) begin
          @(negedge clk);
          check("to_no_early_reverse", 32'(bus.reverseCable), 32'd0);
        end
      end
    end
    @(negedge clk);
    check("to_reverse", 32'(bus.reverseCable), 32'd1);
    check("to_carried_none", 32'(bus.carriedObj), 32'd0);
    @(negedge clk);
    check("to_reel_fast", 32'(bus.reelSpeedSel), 32'd0);
    wait_out(3, 400, "to_idle_timeout");
    bus.launchKey = 1'b0;

    // Rock delivery then key edges during cooldown
    step();
    bus.launchKey = 1'b1;
    sb_push(EV_LAUNCH, 0);
    wait_out(0, 10, "rock_launch_timeout");
    step();
    bus.hookAtHome = 1'b0;
    step();
    bus.hitRock = 1'b1;
    sb_push(EV_REV, 2);
    sb_push(EV_SCORE, 10);
    step();
    bus.hitRock    = 1'b0;
    bus.hookAtHome = 1'b1;
    wait_out(2, 200, "rock_score_timeout");
    check("rock_score_add", 32'(bus.scoreAdd), 32'd10);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < CD * FP * 2; i++) begin
      @(posedge clk);
      if (bus.startOfFrame) n++;
      if (n == CD) break;
      #1;
      if (bus.startOfFrame && n == CD - 1) check("cd_still_busy", 32'(bus.busy), 32'd1);
      bus.launchKey = ~bus.launchKey;
    end
    @(negedge clk);
    check("cd_done_idle", 32'(bus.busy), 32'd0);
    step();
    bus.launchKey = 1'b0;
    step();
    bus.launchKey = 1'b1;
    sb_push(EV_LAUNCH, 0);
    sb_push(EV_REV, 0);
    wait_out(0, 10, "cd_relaunch_timeout");
    wait_out(3, 400, "cd_idle_timeout");
    bus.launchKey = 1'b0;

    // gameEnable rules
    step();
    bus.gameEnable = 1'b0;
    bus.launchKey  = 1'b1;
    repeat (4) @(negedge clk);
    check("en_blocked", 32'(bus.busy), 32'd0);
    step();
    bus.launchKey = 1'b0;
    step();
    bus.gameEnable = 1'b1;
    bus.launchKey  = 1'b1;
    sb_push(EV_LAUNCH, 0);
    sb_push(EV_REV, 1);
    sb_push(EV_SCORE, 50);
    wait_out(0, 10, "en_launch_timeout");
    step();
    bus.hookAtHome = 1'b0;
    bus.gameEnable = 1'b0;
    step();
    bus.hitGold = 1'b1;
    step();
    bus.hitGold = 1'b0;
    wait_sof(1);
    #1 bus.hookAtHome = 1'b1;
    wait_out(2, 200, "en_score_timeout");
    check("en_score_add", 32'(bus.scoreAdd), 32'd50);
    wait_out(3, 400, "en_idle_timeout");
    bus.gameEnable = 1'b1;
    bus.launchKey  = 1'b0;

    // Reset mid-RETRACT with rock on the hook
    step();
    bus.launchKey = 1'b1;
    sb_push(EV_LAUNCH, 0);
    sb_push(EV_REV, 2);
    wait_out(0, 10, "rst_launch_timeout");
    step();
    bus.hookAtHome = 1'b0;
    bus.launchKey  = 1'b0;
    step();
    bus.hitRock = 1'b1;
    step();
    bus.hitRock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_reel_slow", 32'(bus.reelSpeedSel), 32'd2);
    check("rst_carried_rock", 32'(bus.carriedObj), 32'd2);
    #2 resetN = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) step();
    resetN = 1'b1;
    bus.hookAtHome = 1'b1;
    repeat (40) step();
    check("rst_idle_after", 32'(bus.busy), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cable_launch_controller.md
# cable_launch_controller

Sequencing controller for the swinging cable/hook of the mining game. It turns the player's launch key and the object/edge collision inputs into the one-cycle `launch_Cable` and `reverseCable` commands that drive the cable motion block, whose `collision` input `reverseCable` feeds. It also tracks what the hook is carrying and selects reel speed. When the hook returns home it emits the score increment, then enforces a cooldown before the next launch.

## Interface
- `EXTEND_TIMEOUT_FRAMES`, default 90: frames in EXTEND before a forced reverse.
- `COOLDOWN_FRAMES`, default 15: frames spent in COOLDOWN after a return.
- `GOLD_VALUE`, default 50: scoreAdd value for gold (8-bit).
- `ROCK_VALUE`, default 10: scoreAdd value for rock (8-bit).
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `gameEnable` in 1: level; launches are accepted only when 1.
- `launchKey` in 1: raw level from keypad, already synchronous to `clk`.
- `hookAtHome` in 1: level; hook is at its swing position (not extended).
- `hitGold` in 1: level; hook overlaps a gold object.
- `hitRock` in 1: level; hook overlaps a rock object.
- `hitEdge` in 1: level; hook touches a screen border.
- `launch_Cable` out 1: one-cycle launch command.
- `reverseCable` out 1: one-cycle reverse command.
- `reelSpeedSel` out 2: 0 = empty/fast, 1 = gold/medium, 2 = rock/slow; 3 is never driven.
- `carriedObj` out 2: 0 = none, 1 = gold, 2 = rock.
- `scoreValid` out 1: one-cycle pulse when a carried object is delivered.
- `scoreAdd` out 8: increment value, valid only while `scoreValid` = 1, otherwise 0.
- `busy` out 1: 1 in every state except IDLE.

## Operation
- **States:** IDLE, LAUNCH, EXTEND, REVERSE, RETRACT, SCORE, COOLDOWN.
- **Key edge:** `launchKey` is registered as `key_d`; `keyRise = launchKey & !key_d`. A key held down never relaunches. Key edges in any state other than IDLE are discarded, not queued.
- **IDLE → LAUNCH:** when `keyRise & gameEnable & hookAtHome`.
- **LAUNCH:** lasts exactly one cycle, with `launch_Cable` = 1; then EXTEND. The frame counter is cleared.
- **EXTEND:**
  - Counts `startOfFrame` pulses.
  - On `hitGold`: `carriedObj` = 1, go to REVERSE.
  - Else on `hitRock`: `carriedObj` = 2, go to REVERSE.
  - Else on `hitEdge` or count == `EXTEND_TIMEOUT_FRAMES`: `carriedObj` = 0, go to REVERSE.
  - `hookAtHome` is ignored in EXTEND.
- **REVERSE:** lasts one cycle, with `reverseCable` = 1; then RETRACT. The frame counter is cleared.
- **RETRACT:**
  - `reelSpeedSel` = `carriedObj`.
  - Collision inputs are ignored.
  - Goes to SCORE when `hookAtHome` = 1 and at least one `startOfFrame` has been seen in RETRACT. This guards against a reverse issued in the launch frame.
- **SCORE:** lasts one cycle.
  - If `carriedObj` = 1: `scoreValid` = 1, `scoreAdd` = `GOLD_VALUE`.
  - If `carriedObj` = 2: `scoreValid` = 1, `scoreAdd` = `ROCK_VALUE`.
  - If `carriedObj` = 0: no pulse.
  - `carriedObj` is cleared to 0 on exit; then COOLDOWN.
- **COOLDOWN:** counts `startOfFrame` pulses; at `COOLDOWN_FRAMES`, go to IDLE.
- **Frame counter:** 8-bit. It saturates and does not wrap; `EXTEND_TIMEOUT_FRAMES` and `COOLDOWN_FRAMES` must be ≤ 255.
- **Simultaneous collisions:** priority is gold > rock > edge/timeout, all resolved in the same EXTEND cycle.
- **gameEnable low mid-flight:** the current launch completes (EXTEND, RETRACT and SCORE as normal); only new launches are blocked.
- **Outside RETRACT:** `reelSpeedSel` = 0.

## Timing
- **Reset** (asynchronous, any state):
  - State → IDLE.
  - `launch_Cable`, `reverseCable`, `scoreValid` = 0.
  - `scoreAdd`, `carriedObj`, `reelSpeedSel` = 0.
  - `busy` = 0; counters and `key_d` = 0.
- **All outputs are registered.**
- **Launch latency:** `keyRise` sampled in cycle N → `launch_Cable` high in cycle N+1 only; EXTEND from N+2.
- **Reverse latency:** qualifying hit sampled in EXTEND at cycle M → `carriedObj` valid and `reverseCable` high in M+1 only → RETRACT from M+2.
- **Timeout:** the timeout condition is evaluated in the cycle that registers the `EXTEND_TIMEOUT_FRAMES`-th `startOfFrame`; reverse follows one cycle later.
- **Score latency:** the RETRACT exit condition in cycle K → `scoreValid` pulse in K+1 → COOLDOWN from K+2.
- **Minimum spacing between `launch_Cable` pulses:** at least `COOLDOWN_FRAMES` + 1 frames.

## Test plan
- **Basic launch:** reset; IDLE with `hookAtHome` = 1, `gameEnable` = 1; raise `launchKey` at cycle 10 and hold for 1000 cycles → exactly one `launch_Cable` pulse at cycle 11, `busy` = 1 from cycle 11.
- **Gold catch:** during EXTEND, `hitGold` = 1 and `hitRock` = 1 in the same cycle → one `reverseCable` pulse the next cycle, `carriedObj` = 1, `reelSpeedSel` = 1 in RETRACT. Set `hookAtHome` = 1 after 3 frames → `scoreValid` for one cycle with `scoreAdd` = 50, then `carriedObj` = 0.
- **Timeout miss:** launch with no hits and `EXTEND_TIMEOUT_FRAMES` = 4 → `reverseCable` one cycle after the 4th `startOfFrame`, `carriedObj` = 0; on return, no `scoreValid`.
- **Cooldown:** after a rock delivery (`scoreAdd` = 10), key edges during COOLDOWN (`COOLDOWN_FRAMES` = 15) → no launch. A key edge after the 15th frame → launch.
- **Enable and edge rules:** `gameEnable` = 0 with `keyRise` → no launch. Drop `gameEnable` during EXTEND → the cycle still reverses, retracts and scores normally.
- **Reset mid-operation:** assert `resetN` = 0 in RETRACT with `carriedObj` = 2 → all outputs 0 immediately, IDLE after release, no `scoreValid`.
